fetch_sequencer: RTL and testbench

//  Instruction-fetch controller for the single-issue RV32 core. Owns the program counter.

---
 rtl/rv_fetch_pkg.sv | 13 +
 rtl/fetch_sequencer_pc_reg.sv | 30 +++
 rtl/fetch_sequencer.sv | 98 +++++++++
 tb/tb_fetch_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types for the instruction-fetch sequencer.
// State encoding and fetch granule size.
package rv_fetch_pkg;
  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    DISCARD,
    HOLD
  } fetch_state_e;

  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter register for the fetch sequencer.
// Word-aligned: the low two address bits are always forced to zero.
module pc_reg
  import rv_fetch_pkg::*;
#(
  parameter int                 PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_val,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);

  localparam logic [PC_WIDTH-1:0] STEP  = PC_WIDTH'(INSTR_BYTES);
  localparam logic [PC_WIDTH-1:0] ALIGN = ~(STEP - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC & ALIGN;
    end else if (load) begin
      pc <= load_val & ALIGN;
    end else if (inc) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: one outstanding imem request,
// redirect handling with stale-response discard, decode handoff.
module fetch_sequencer
  import rv_fetch_pkg::*;
#(
  parameter int                 PC_WIDTH   = 16,
  parameter int                 DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_target,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [PC_WIDTH-1:0]   imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]   if_pc
);

  fetch_state_e        state_q;
  fetch_state_e        state_d;
  logic                capture;
  logic                pc_inc;
  logic [PC_WIDTH-1:0] pc_q;

  pc_reg #(
    .PC_WIDTH(PC_WIDTH),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .load    (redirect_valid),
    .load_val(redirect_target),
    .inc     (pc_inc),
    .pc      (pc_q)
  );

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;
  // Masked so a wrong-path instruction can never transfer.
  assign if_valid       = (state_q == HOLD) && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= BOOT;
      if_instr <= '0;
      if_pc    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        if_instr <= imem_rsp_data;
        if_pc    <= pc_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    pc_inc  = 1'b0;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (redirect_valid) begin
          if (imem_req_ready) state_d = DISCARD;
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rsp_valid ? REQ : DISCARD;
        end else if (imem_rsp_valid) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      DISCARD: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d = REQ;
        end else if (if_ready) begin
          pc_inc  = 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = BOOT;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed redirect/stall/wrap
// scenarios against a variable-latency instruction memory model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [15:0] if_pc;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned req_cnt = 0;
  int unsigned lat = 1;
  int unsigned cnt;
  logic [15:0] a_q;
  logic [15:0] exp_req[$];
  logic [15:0] exp_if[$];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  // Memory model: responds lat cycles after acceptance with {C0DE, addr}.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 0;
      a_q <= '0;
    end else begin
      if (cnt != 0) cnt <= cnt - 1;
      if (imem_req_valid && imem_req_ready) begin
        cnt <= lat;
        a_q <= imem_req_addr;
      end
    end
  end
  assign imem_rsp_valid = (cnt == 1);
  assign imem_rsp_data  = {16'hC0DE, a_q};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        req_cnt++;
        chk("req_expected", 32'(exp_req.size() != 0), 1);
        if (exp_req.size() != 0) chk("req_addr", 32'(imem_req_addr), 32'(exp_req.pop_front()));
      end
      if (if_valid && if_ready) begin
        chk("if_expected", 32'(exp_if.size() != 0), 1);
        if (exp_if.size() != 0) begin
          logic [15:0] p;
          p = exp_if.pop_front();
          chk("if_pc", 32'(if_pc), 32'(p));
          chk("if_instr", if_instr, {16'hC0DE, p});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_req_valid"}, 32'(imem_req_valid), 0);
    chk({nm, "_req_addr"}, 32'(imem_req_addr), 0);
    chk({nm, "_if_valid"}, 32'(if_valid), 0);
    chk({nm, "_if_instr"}, if_instr, 0);
    chk({nm, "_if_pc"}, 32'(if_pc), 0);
  endtask

  task automatic wait_if();
    int k;
    k = 0;
    while (!if_valid && k < 30) begin
      tick();
      k++;
    end
    if (!if_valid) chk("if_valid_timeout", 32'(if_valid), 1);
  endtask

  task automatic consume(input logic [15:0] pc, input bit push_next);
    logic [15:0] nxt;
    nxt = pc + 16'd4;
    wait_if();
    exp_if.push_back(pc);
    if (push_next) exp_req.push_back(nxt);
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  initial begin
    int unsigned c0;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    imem_req_ready = 1'b1;
    if_ready = 1'b0;
    repeat (2) tick();
    chk_zero("reset");

    // Sequential fetch 0x0, 0x4, 0x8
    exp_req.push_back(16'h0000);
    rst = 1'b0;
    consume(16'h0000, 1);
    consume(16'h0004, 1);
    consume(16'h0008, 1);

    // Decode stall in HOLD
    wait_if();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(if_valid), 1);
      chk("stall_pc", 32'(if_pc), 32'h000C);
      chk("stall_instr", if_instr, 32'hC0DE000C);
      chk("stall_noreq", 32'(imem_req_valid), 0);
      tick();
    end
    consume(16'h000C, 1);

    // Redirect in WAIT coinciding with response
    tick();
    redirect_valid = 1'b1;
    redirect_target = 16'h0103;
    exp_req.push_back(16'h0100);
    tick();
    redirect_valid = 1'b0;
    chk("wait_redir_if_valid", 32'(if_valid), 0);
    chk("wait_redir_addr", 32'(imem_req_addr), 32'h0100);
    consume(16'h0100, 0);

    // Redirect in WAIT before response -> DISCARD
    lat = 3;
    exp_req.push_back(16'h0104);
    tick();
    redirect_valid = 1'b1;
    redirect_target = 16'h0200;
    exp_req.push_back(16'h0200);
    tick();
    redirect_valid = 1'b0;
    chk("discard_noreq", 32'(imem_req_valid), 0);
    chk("discard_if_valid", 32'(if_valid), 0);
    consume(16'h0200, 1);
    lat = 1;

    // Redirect in HOLD masks if_valid
    wait_if();
    redirect_valid = 1'b1;
    redirect_target = 16'h0300;
    if_ready = 1'b1;
    exp_req.push_back(16'h0300);
    #1;
    chk("hold_redir_mask", 32'(if_valid), 0);
    tick();
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    consume(16'h0300, 0);

    // Stalled request with redirect on cycle 2
    imem_req_ready = 1'b0;
    c0 = req_cnt;
    chk("stall_req_valid", 32'(imem_req_valid), 1);
    chk("stall_req_c1", 32'(imem_req_addr), 32'h0304);
    tick();
    chk("stall_req_c2", 32'(imem_req_addr), 32'h0304);
    redirect_valid = 1'b1;
    redirect_target = 16'h0402;
    tick();
    redirect_valid = 1'b0;
    chk("stall_req_c3", 32'(imem_req_addr), 32'h0400);
    tick();
    exp_req.push_back(16'h0400);
    imem_req_ready = 1'b1;
    tick();
    chk("one_transfer", req_cnt - c0, 1);
    consume(16'h0400, 0);

    // Redirect on accepting REQ, then wrap at 0xFFFC
    exp_req.push_back(16'h0404);
    exp_req.push_back(16'hFFFC);
    redirect_valid = 1'b1;
    redirect_target = 16'hFFFC;
    tick();
    redirect_valid = 1'b0;
    consume(16'hFFFC, 1);
    chk("wrap_addr", 32'(imem_req_addr), 32'h0000);
    chk("wrap_valid", 32'(imem_req_valid), 1);
    tick();

    // Async reset mid-WAIT
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    imem_req_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("req_q_drained", exp_req.size(), 0);
    chk("if_q_drained", exp_if.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
